pool_engine: RTL and testbench
==============================

POOL_ENGINE -- requirements
Module: pool_engine

Interface
REQ-001 Parameter DATA_SZ, default 16, pixel and size-field width in bits.
REQ-002 Parameter ADDR_SZ, default 16, memory address width in bits.
REQ-003 Parameter MAX_WIN, default 8, largest accepted windowSize.
REQ-004 Port clk  in  1  single clock; all logic on posedge clk.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port start  in  1  one-cycle request to begin a job; sampled only when not busy.
REQ-007 Port mode  in  1  0 = max pooling, 1 = average pooling; latched at start.
REQ-008 Ports imgsNumber, imgSize, windowSize  in  DATA_SZ each  image count, square image side, square window side; latched at start.
REQ-009 Ports imgsAddress, outAddress  in  ADDR_SZ each  input base address, output base address; latched at start.
REQ-010 Ports rdEnable out 1, rdAddr out ADDR_SZ, rdData in DATA_SZ signed  memory read; rdData valid exactly one cycle after rdEnable.
REQ-011 Ports wrEnable out 1, wrAddr out ADDR_SZ, wrData out DATA_SZ signed  result write, one word per wrEnable cycle.
REQ-012 Ports busy, done, cfgErr  out 1 each  job active, job finished (held), configuration rejected (held).

Function
REQ-013 States: IDLE, READ, LAST, WRITE, FINISH; start in IDLE (or FINISH) with valid config -> READ, busy=1, done=0, cfgErr=0.
REQ-014 Config invalid when windowSize=0, windowSize>MAX_WIN, windowSize>imgSize, or imgsNumber=0: start -> FINISH with cfgErr=1, no rdEnable/wrEnable issued.
REQ-015 outSize = floor(imgSize/windowSize); trailing rows/columns beyond outSize*windowSize are ignored.
REQ-016 Loop order: image n, output row r, output column c, window row i, window column j (j innermost).
REQ-017 rdAddr = imgsAddress + n*imgSize*imgSize + (r*windowSize+i)*imgSize + (c*windowSize+j), truncated modulo 2^ADDR_SZ.
REQ-018 READ issues one rdEnable per cycle for windowSize*windowSize consecutive cycles, then -> LAST; LAST captures final rdData, then -> WRITE.
REQ-019 WRITE asserts wrEnable for one cycle; wrAddr = outAddress + running output index (n*outSize*outSize + r*outSize + c), modulo 2^ADDR_SZ.
REQ-020 Per output: windowSize*windowSize + 2 cycles; no bubbles between outputs.
REQ-021 Max mode: accumulator initialised to most-negative DATA_SZ value each window; signed compare.
REQ-022 Average mode: signed sum in DATA_SZ+6 bits, wrData = sum arithmetic-shifted right by log2(windowSize^2) (floor), truncated to DATA_SZ.
REQ-023 After final write -> FINISH: busy=0, done=1 next cycle; done/cfgErr held until next accepted start or reset.
REQ-024 start while busy is ignored; latched configuration unaffected by input changes mid-job.
REQ-025 rdEnable and wrEnable never asserted in the same cycle.

Reset
REQ-026 reset, at any time including mid-job, forces IDLE next cycle: busy, done, cfgErr, rdEnable, wrEnable = 0; rdAddr, wrAddr, wrData = 0; all counters cleared.
REQ-027 reset has priority over start in the same cycle.

Configuration
REQ-028 Macro POOL_AVG_EN defined: average mode available; mode=1 with windowSize not in {1,2,4,8} is invalid (cfgErr).
REQ-029 Macro POOL_AVG_EN undefined: averaging logic absent, mode ignored, max pooling always used, no mode-related cfgErr.

Verification
REQ-030 4x4 image pixels 0..15 at 0x0100, win 2, max, outAddress 0x0200 -> writes 5,7,13,15 to 0x0200..0x0203; done 25 cycles after start.
REQ-031 Same image, mode=1, POOL_AVG_EN -> writes 2,4,10,12; 4x4 of all -3, win 2, avg -> writes -3 (floor of -12/4).
REQ-032 Two 3x3 images at 0x0000, win 2, max -> reads from bases 0x0000 and 0x0009 only rows/cols 0-1; two writes to outAddress, outAddress+1.
REQ-033 windowSize 0, then windowSize 5 with imgSize 4, then (POOL_AVG_EN) win 3 avg -> cfgErr=1, done=1, zero reads/writes each time.
REQ-034 reset asserted during READ of second output -> next cycle IDLE, all outputs 0; new start runs job fully with correct results.
REQ-035 start pulsed mid-job with different imgSize -> ignored; results match original latched config.

Source files
------------

// File: rtl/pool_if.sv
// Start/configuration, memory-read and result-write bundle for pool_engine.
interface pool_if #(
   parameter int DATA_SZ = 16,
   parameter int ADDR_SZ = 16
);
   logic                      start;
   logic                      mode;
   logic        [DATA_SZ-1:0] imgsNumber;
   logic        [DATA_SZ-1:0] imgSize;
   logic        [DATA_SZ-1:0] windowSize;
   logic        [ADDR_SZ-1:0] imgsAddress;
   logic        [ADDR_SZ-1:0] outAddress;
   logic                      rdEnable;
   logic        [ADDR_SZ-1:0] rdAddr;
   logic signed [DATA_SZ-1:0] rdData;
   logic                      wrEnable;
   logic        [ADDR_SZ-1:0] wrAddr;
   logic signed [DATA_SZ-1:0] wrData;
   logic                      busy;
   logic                      done;
   logic                      cfgErr;

   modport master (
      output start, mode, imgsNumber, imgSize, windowSize, imgsAddress, outAddress, rdData,
      input  rdEnable, rdAddr, wrEnable, wrAddr, wrData, busy, done, cfgErr
   );

   modport slave (
      input  start, mode, imgsNumber, imgSize, windowSize, imgsAddress, outAddress, rdData,
      output rdEnable, rdAddr, wrEnable, wrAddr, wrData, busy, done, cfgErr
   );
endinterface

// File: rtl/pool_engine.sv
// Max/average pooling engine streaming square windows from memory, one result word per window.
// Define POOL_AVG_EN to build the average-pooling datapath (mode=1); otherwise max pooling only.
module pool_engine #(
   parameter int DATA_SZ = 16,
   parameter int ADDR_SZ = 16,
   parameter int MAX_WIN = 8
) (
   input  logic  clk,
   input  logic  reset,
   pool_if.slave bus
);
   localparam int ACC_SZ = DATA_SZ + 6;

   typedef enum logic [2:0] {IDLE, READ, LAST, WRITE, FINISH} state_t;
   state_t state, state_nxt;

   logic        [DATA_SZ-1:0] imgs_q, img_q, win_q, n_q, i_q, j_q, colpos, rowpos;
   logic        [ADDR_SZ-1:0] out_base, img_sq, win_row, out_idx;
   logic        [ADDR_SZ-1:0] img_ptr, orow_ptr, blk_ptr, line_ptr, rd_addr, wr_addr;
   logic signed [DATA_SZ-1:0] wr_data, res;
   logic signed [ACC_SZ-1:0]  acc, acc_nxt, rd_ext;
   logic                      rd_vld, last_out, cfg_err;
   logic                      idle_like, cfg_ok, accept, reject;
   logic                      j_last, i_last, win_last, col_more, row_more, img_more;
   logic                      avg_sel, mode_in;
   logic      [2*DATA_SZ-1:0] sq_prod, wr_prod;
   logic        [DATA_SZ+1:0] col_end, row_end;
   logic        [ADDR_SZ-1:0] img_a, win_a;

   function automatic logic signed [ACC_SZ-1:0] acc_init(input logic avg);
      return avg ? '0 : {{7{1'b1}}, {(DATA_SZ-1){1'b0}}};
   endfunction

   assign idle_like = (state == IDLE) || (state == FINISH);
   assign accept    = idle_like && bus.start && cfg_ok;
   assign reject    = idle_like && bus.start && !cfg_ok;

   assign sq_prod = {{DATA_SZ{1'b0}}, bus.imgSize} * {{DATA_SZ{1'b0}}, bus.imgSize};
   assign wr_prod = {{DATA_SZ{1'b0}}, bus.windowSize} * {{DATA_SZ{1'b0}}, bus.imgSize};
   assign img_a   = ADDR_SZ'(img_q);
   assign win_a   = ADDR_SZ'(win_q);

   // Next window fits only if its far edge stays inside the image; leftovers are skipped.
   assign col_end  = {2'b00, colpos} + {1'b0, win_q, 1'b0};
   assign row_end  = {2'b00, rowpos} + {1'b0, win_q, 1'b0};
   assign col_more = col_end <= {2'b00, img_q};
   assign row_more = row_end <= {2'b00, img_q};
   assign img_more = n_q != imgs_q - DATA_SZ'(1);
   assign j_last   = j_q == win_q - DATA_SZ'(1);
   assign i_last   = i_q == win_q - DATA_SZ'(1);
   assign win_last = j_last && i_last;

   assign rd_ext = {{(ACC_SZ-DATA_SZ){bus.rdData[DATA_SZ-1]}}, bus.rdData};

`ifdef POOL_AVG_EN
   logic       avg_q, pow2_win;
   logic [2:0] sh_q, sh_in;

   always_comb begin
      sh_in    = 3'd0;
      pow2_win = 1'b1;
      case (bus.windowSize)
         DATA_SZ'(1): sh_in = 3'd0;
         DATA_SZ'(2): sh_in = 3'd2;
         DATA_SZ'(4): sh_in = 3'd4;
         DATA_SZ'(8): sh_in = 3'd6;
         default:     pow2_win = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         avg_q <= 1'b0;
         sh_q  <= 3'd0;
      end else if (accept) begin
         avg_q <= bus.mode;
         sh_q  <= sh_in;
      end
   end

   assign mode_in = bus.mode;
   assign avg_sel = avg_q;
   assign acc_nxt = !rd_vld ? acc : avg_q ? acc + rd_ext : ((rd_ext > acc) ? rd_ext : acc);
   assign res     = DATA_SZ'(acc_nxt >>> sh_q);
`else
   logic unused_mode;
   assign unused_mode = bus.mode;
   assign mode_in     = 1'b0;
   assign avg_sel     = 1'b0;
   assign acc_nxt     = (rd_vld && (rd_ext > acc)) ? rd_ext : acc;
   assign res         = DATA_SZ'(acc_nxt);
`endif

   always_comb begin
      cfg_ok = (bus.windowSize != '0) && (bus.windowSize <= DATA_SZ'(MAX_WIN)) &&
               (bus.windowSize <= bus.imgSize) && (bus.imgsNumber != '0);
`ifdef POOL_AVG_EN
      if (bus.mode && !pow2_win) cfg_ok = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, FINISH: if (bus.start) state_nxt = cfg_ok ? READ : FINISH;
         READ:         if (win_last) state_nxt = LAST;
         LAST:         state_nxt = WRITE;
         WRITE:        state_nxt = last_out ? FINISH : READ;
         default:      state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.rdEnable = (state == READ);
      bus.wrEnable = (state == WRITE);
      bus.busy     = (state == READ) || (state == LAST) || (state == WRITE);
      bus.done     = (state == FINISH);
   end

   // Address walk is incremental: pointers to image, output row, window block and window line.
   always_ff @(posedge clk) begin
      if (reset) begin
         imgs_q <= '0; img_q <= '0; win_q <= '0; out_base <= '0; img_sq <= '0; win_row <= '0;
         n_q <= '0; i_q <= '0; j_q <= '0; colpos <= '0; rowpos <= '0; out_idx <= '0;
         img_ptr <= '0; orow_ptr <= '0; blk_ptr <= '0; line_ptr <= '0;
         rd_addr <= '0; wr_addr <= '0; wr_data <= '0; acc <= '0;
         rd_vld <= 1'b0; last_out <= 1'b0; cfg_err <= 1'b0;
      end else begin
         rd_vld <= (state == READ);
         acc    <= acc_nxt;
         if (accept) begin
            imgs_q   <= bus.imgsNumber;
            img_q    <= bus.imgSize;
            win_q    <= bus.windowSize;
            out_base <= bus.outAddress;
            img_sq   <= ADDR_SZ'(sq_prod);
            win_row  <= ADDR_SZ'(wr_prod);
            n_q <= '0; i_q <= '0; j_q <= '0; colpos <= '0; rowpos <= '0; out_idx <= '0;
            img_ptr  <= bus.imgsAddress;
            orow_ptr <= bus.imgsAddress;
            blk_ptr  <= bus.imgsAddress;
            line_ptr <= bus.imgsAddress;
            rd_addr  <= bus.imgsAddress;
            acc      <= acc_init(mode_in);
            last_out <= 1'b0;
            cfg_err  <= 1'b0;
         end else if (reject) begin
            cfg_err <= 1'b1;
         end
         case (state)
            READ: begin
               if (!j_last) begin
                  j_q     <= j_q + DATA_SZ'(1);
                  rd_addr <= rd_addr + ADDR_SZ'(1);
               end else begin
                  j_q <= '0;
                  if (!i_last) begin
                     i_q      <= i_q + DATA_SZ'(1);
                     line_ptr <= line_ptr + img_a;
                     rd_addr  <= line_ptr + img_a;
                  end else begin
                     i_q      <= '0;
                     last_out <= !col_more && !row_more && !img_more;
                     if (col_more) begin
                        colpos   <= colpos + win_q;
                        blk_ptr  <= blk_ptr + win_a;
                        line_ptr <= blk_ptr + win_a;
                        rd_addr  <= blk_ptr + win_a;
                     end else if (row_more) begin
                        colpos   <= '0;
                        rowpos   <= rowpos + win_q;
                        orow_ptr <= orow_ptr + win_row;
                        blk_ptr  <= orow_ptr + win_row;
                        line_ptr <= orow_ptr + win_row;
                        rd_addr  <= orow_ptr + win_row;
                     end else begin
                        colpos   <= '0;
                        rowpos   <= '0;
                        n_q      <= n_q + DATA_SZ'(1);
                        img_ptr  <= img_ptr + img_sq;
                        orow_ptr <= img_ptr + img_sq;
                        blk_ptr  <= img_ptr + img_sq;
                        line_ptr <= img_ptr + img_sq;
                        rd_addr  <= img_ptr + img_sq;
                     end
                  end
               end
            end
            LAST: begin
               wr_data <= res;
               wr_addr <= out_base + out_idx;
               acc     <= acc_init(avg_sel);
            end
            WRITE:   out_idx <= out_idx + ADDR_SZ'(1);
            default: ;
         endcase
      end
   end

   assign bus.rdAddr = rd_addr;
   assign bus.wrAddr = wr_addr;
   assign bus.wrData = wr_data;
   assign bus.cfgErr = cfg_err;
endmodule

// File: tb/tb_pool_engine.sv
// Directed bench for pool_engine: memory responder, loop-nest reference model, per-cycle monitor.
module tb_pool_engine;
   localparam int DW = 16;
   localparam int AW = 16;
`ifdef POOL_AVG_EN
   localparam bit AVG_BUILD = 1'b1;
`else
   localparam bit AVG_BUILD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pool_if #(.DATA_SZ(DW), .ADDR_SZ(AW)) bus ();
   pool_engine #(.DATA_SZ(DW), .ADDR_SZ(AW), .MAX_WIN(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   logic signed [DW-1:0] mem [0:65535];
   int tests = 0, failed = 0;
   int exp_rd[$], exp_wa[$], exp_wd[$], log_wa[$], log_wd[$];
   int rd_cnt = 0, wr_cnt = 0, rd0 = 0, wr0 = 0, exp_reads = 0, exp_writes = 0, last_k = 0;
   logic          pend = 1'b0;
   logic [AW-1:0] pend_a = '0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   function automatic int floordiv(input int a, input int d);
      int q;
      q = a / d;
      if ((a % d != 0) && (a < 0)) q--;
      return q;
   endfunction

   // Reference: plain loop nest over images, output rows/cols and window pixels.
   task automatic model(input int nimg, input int img, input int w, input int ia, input int oa, input bit avg);
      int os, idx, acc, a, v;
      logic signed [15:0] t;
      os = img / w;
      idx = 0;
      for (int n = 0; n < nimg; n++)
         for (int r = 0; r < os; r++)
            for (int c = 0; c < os; c++) begin
               acc = avg ? 0 : -32768;
               for (int i = 0; i < w; i++)
                  for (int j = 0; j < w; j++) begin
                     a = (ia + n*img*img + (r*w + i)*img + c*w + j) & 'hFFFF;
                     v = mem[a];
                     exp_rd.push_back(a);
                     if (avg) acc += v;
                     else if (v > acc) acc = v;
                  end
               if (avg) acc = floordiv(acc, w*w);
               t = acc[15:0];
               exp_wa.push_back((oa + idx) & 'hFFFF);
               exp_wd.push_back(t);
               idx++;
            end
      exp_reads  = nimg*os*os*w*w;
      exp_writes = nimg*os*os;
   endtask

   // Memory: data for a read request appears during the following cycle.
   always @(negedge clk) begin
      pend   = bus.rdEnable;
      pend_a = bus.rdAddr;
      if (!reset) begin
         if (bus.rdEnable || bus.wrEnable) chk("rd_wr_exclusive", bus.rdEnable & bus.wrEnable, 0);
         if (bus.rdEnable) begin
            rd_cnt++;
            if (exp_rd.size() == 0) chk("unexpected_read", bus.rdAddr, -1);
            else chk("rdAddr", bus.rdAddr, exp_rd.pop_front());
         end
         if (bus.wrEnable) begin
            wr_cnt++;
            log_wa.push_back(bus.wrAddr);
            log_wd.push_back(bus.wrData);
            if (exp_wa.size() == 0) chk("unexpected_write", bus.wrAddr, -1);
            else begin
               chk("wrAddr", bus.wrAddr, exp_wa.pop_front());
               chk("wrData", bus.wrData, exp_wd.pop_front());
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      bus.rdData = pend ? mem[pend_a] : 16'sh7FFF;
   end

   task automatic launch(input int nimg, input int img, input int w, input int ia, input int oa,
                         input bit md, input bit err);
      exp_rd.delete(); exp_wa.delete(); exp_wd.delete(); log_wa.delete(); log_wd.delete();
      exp_reads = 0; exp_writes = 0;
      if (!err) model(nimg, img, w, ia, oa, md && AVG_BUILD);
      bus.imgsNumber  = 16'(nimg);
      bus.imgSize     = 16'(img);
      bus.windowSize  = 16'(w);
      bus.imgsAddress = 16'(ia);
      bus.outAddress  = 16'(oa);
      bus.mode        = md;
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic finish_job(input string nm, input int exp_k, input bit err);
      int k;
      bit busy_ok;
      k = 0;
      busy_ok = 1'b1;
      while (!bus.done && k < 5000) begin
         if (!bus.busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         k++;
      end
      last_k = k;
      chk({nm, "_done"}, bus.done, 1);
      if (exp_k >= 0) chk({nm, "_latency"}, k, exp_k);
      chk({nm, "_cfgErr"}, bus.cfgErr, err);
      chk({nm, "_busy_end"}, bus.busy, 0);
      chk({nm, "_busy_held"}, busy_ok, 1);
      chk({nm, "_reads"}, rd_cnt - rd0, exp_reads);
      chk({nm, "_writes"}, wr_cnt - wr0, exp_writes);
      chk({nm, "_rd_left"}, exp_rd.size(), 0);
   endtask

   task automatic run_job(input string nm, input int nimg, input int img, input int w, input int ia,
                          input int oa, input bit md, input bit err);
      int os;
      launch(nimg, img, w, ia, oa, md, err);
      os = err ? 0 : img / w;
      finish_job(nm, err ? 0 : nimg*os*os*(w*w + 2), err);
   endtask

   task automatic chk_log(input string nm, input int i, input int wa, input int wd);
      if (i < log_wd.size()) begin
         chk({nm, "_addr"}, log_wa[i], wa);
         chk({nm, "_data"}, log_wd[i], wd);
      end else chk({nm, "_missing"}, log_wd.size(), i + 1);
   endtask

   task automatic chk_idle_zero(input string nm);
      chk({nm, "_busy"}, bus.busy, 0);
      chk({nm, "_done"}, bus.done, 0);
      chk({nm, "_cfgErr"}, bus.cfgErr, 0);
      chk({nm, "_rdEnable"}, bus.rdEnable, 0);
      chk({nm, "_wrEnable"}, bus.wrEnable, 0);
      chk({nm, "_rdAddr"}, bus.rdAddr, 0);
      chk({nm, "_wrAddr"}, bus.wrAddr, 0);
      chk({nm, "_wrData"}, bus.wrData, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int im3[18];
      int mx[4], av[4];
      im3 = '{1, -2, 9, 3, -4, 9, 9, 9, 9, -7, -8, 9, -6, -5, 9, 9, 9, 9};
      mx  = '{5, 7, 13, 15};
      av  = '{2, 4, 10, 12};
      for (int a = 0; a < 65536; a++) mem[a] = 16'((a*13 + 5) % 97 - 48);
      for (int a = 0; a < 16; a++) begin
         mem['h100 + a] = 16'(a);
         mem['h300 + a] = -16'sd3;
      end
      for (int a = 0; a < 18; a++) mem[a] = 16'(im3[a]);
      for (int a = 0; a < 64; a++) mem['h1000 + a] = 16'((a*37) % 200 - 100);

      bus.start = 1'b0; bus.mode = 1'b0; bus.imgsNumber = '0; bus.imgSize = '0;
      bus.windowSize = '0; bus.imgsAddress = '0; bus.outAddress = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_idle_zero("reset");
      reset = 1'b0;

      // Rejected configurations: FINISH with cfgErr, no memory traffic.
      run_job("cfg_w0", 1, 4, 0, 'h100, 'h200, 1'b0, 1'b1);
      run_job("cfg_w5", 1, 4, 5, 'h100, 'h200, 1'b0, 1'b1);
      run_job("cfg_w9", 1, 16, 9, 'h100, 'h200, 1'b0, 1'b1);
      run_job("cfg_n0", 0, 4, 2, 'h100, 'h200, 1'b0, 1'b1);
      run_job("cfg_avg3", 1, 4, 3, 'h100, 'h200, 1'b1, AVG_BUILD);

      run_job("max4x4", 1, 4, 2, 'h100, 'h200, 1'b0, 1'b0);
      chk("max4x4_done_cycle", last_k + 1, 25);
      for (int i = 0; i < 4; i++) chk_log("max4x4_lit", i, 'h200 + i, mx[i]);

      run_job("avg4x4", 1, 4, 2, 'h100, 'h210, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) chk_log("avg4x4_lit", i, 'h210 + i, AVG_BUILD ? av[i] : mx[i]);

      run_job("avg_neg", 1, 4, 2, 'h300, 'h220, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) chk_log("avg_neg_lit", i, 'h220 + i, -3);

      run_job("two3x3", 2, 3, 2, 'h0000, 'h400, 1'b0, 1'b0);
      chk_log("two3x3_lit0", 0, 'h400, 3);
      chk_log("two3x3_lit1", 1, 'h401, -5);

      run_job("win8", 1, 8, 8, 'h1000, 'h500, 1'b1, 1'b0);
      run_job("img9w4", 2, 9, 4, 'h2000, 'h510, 1'b0, 1'b0);
      run_job("wrap", 1, 4, 2, 'hFFFA, 'hFFFF, 1'b0, 1'b0);
      run_job("w1avg", 1, 3, 1, 'h1000, 'h520, 1'b1, 1'b0);

      // Reset during the second output's READ phase.
      launch(1, 4, 2, 'h100, 'h200, 1'b0, 1'b0);
      repeat (6) begin @(posedge clk); #1; end
      chk("midreset_in_read", bus.rdEnable, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk_idle_zero("midreset");
      reset = 1'b0;
      run_job("after_reset", 1, 4, 2, 'h100, 'h260, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) chk_log("after_reset_lit", i, 'h260 + i, mx[i]);

      // Reset and start together: reset wins, nothing starts.
      bus.imgsNumber = 16'd1; bus.imgSize = 16'd4; bus.windowSize = 16'd2;
      bus.start = 1'b1; reset = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; reset = 1'b0;
      chk("rst_prio_busy", bus.busy, 0);
      chk("rst_prio_done", bus.done, 0);
      @(posedge clk); #1;
      chk("rst_prio_rdEnable", bus.rdEnable, 0);

      // Start with a different configuration mid-job is ignored.
      launch(1, 4, 2, 'h100, 'h240, 1'b0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      bus.imgSize = 16'd8; bus.windowSize = 16'd4; bus.imgsAddress = 16'h1000; bus.outAddress = 16'h600;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      finish_job("midstart", 20, 1'b0);
      for (int i = 0; i < 4; i++) chk_log("midstart_lit", i, 'h240 + i, mx[i]);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
